// File: rtl/counter_sequencer.sv
// Command sequencer for the 4-bit multi-mode counter: preload, run for N rco wraps, report done/err.
// Outputs are registered from the next state so they line up with the state they describe.
module counter_sequencer #(
  parameter int WIDTH   = 4,
  parameter int WRAP_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [WRAP_W-1:0] cmd_wraps,
  input  logic              abort,
  output logic              ctr_enable,
  output logic [1:0]        ctr_mode,
  output logic [WIDTH-1:0]  ctr_D,
  input  logic              ctr_rco,
  input  logic              ctr_load,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_mode;
  logic [WIDTH-1:0]  r_data;
  logic [WRAP_W-1:0] r_wraps, r_wrap, w_wrap_inc;
  logic [TO_W-1:0]   r_to;
  logic              w_accept;
  logic              w_enable, w_ready, w_busy, w_done, w_err;
  logic [1:0]        w_mode;
  logic [WIDTH-1:0]  w_D;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_wrap_inc = r_wrap + 1'b1;

  // State register plus registered outputs, wrap counter and load timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_data     <= '0;
      r_wraps    <= '0;
      r_wrap     <= '0;
      r_to       <= '0;
      cmd_ready  <= 1'b1;
      ctr_enable <= 1'b0;
      ctr_mode   <= 2'b00;
      ctr_D      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_next;
      cmd_ready  <= w_ready;
      ctr_enable <= w_enable;
      ctr_mode   <= w_mode;
      ctr_D      <= w_D;
      busy       <= w_busy;
      done       <= w_done;
      err        <= w_err;
      if (w_accept) begin
        r_mode  <= cmd_mode;
        r_data  <= cmd_data;
        r_wraps <= cmd_wraps;
        r_wrap  <= '0;
      end else if (r_state == S_RUN && ctr_rco && !abort) begin
        r_wrap <= w_wrap_inc;
      end
      r_to <= (r_state == S_LOAD) ? r_to + TO_W'(1) : '0;
    end
  end

  // Abort outranks load acknowledge, timeout and rco
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD;
      S_LOAD: begin
        if (abort)                              w_next = S_IDLE;
        else if (ctr_load)                      w_next = (r_mode == 2'b11 || r_wraps == '0) ? S_DONE : S_RUN;
        else if (r_to == TO_W'(TIMEOUT - 1))    w_next = S_ERR;
      end
      S_RUN: begin
        if (abort)                              w_next = S_IDLE;
        else if (ctr_rco && w_wrap_inc == r_wraps) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Mode/data hold their last value outside LOAD/RUN
  always_comb begin
    w_enable = (w_next == S_LOAD) || (w_next == S_RUN);
    w_ready  = (w_next == S_IDLE);
    w_busy   = (w_next != S_IDLE);
    w_done   = (w_next == S_DONE);
    w_err    = (w_next == S_ERR);
    w_mode   = ctr_mode;
    w_D      = ctr_D;
    if (w_next == S_LOAD)     w_mode = 2'b11;
    else if (w_next == S_RUN) w_mode = r_mode;
    if (w_accept)             w_D = cmd_data;
  end
endmodule
